led_pwm_ctrl: RTL and testbench
===============================

Name: led_pwm_ctrl

Overview:
- Parametrised successor to the single 8-bit LED I/O register.
- Bus-addressed controller for NUM_LEDS LED outputs. Each channel has its own mode: off, on, blink or PWM dim.
- Sits on the same simple wr_en/rd_en register bus as the other fabric peripherals and drives the board LED pins directly.
- A shared timebase (prescaler, PWM counter, blink phase) serves all channels.

Parameters:
- NUM_LEDS, 8, number of LED channels (1..8).
- DATA_W, 8, bus data width.
- ADDR_W, 5, bus address width. Must cover 4+2*NUM_LEDS-1.
- PWM_W, 8, PWM counter and duty width (PWM_W <= DATA_W).
- PRESC_DIV, 4, clocks per PWM tick (>=1).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- nreset, input, 1, synchronous active-low reset.
- wr_en, input, 1, write strobe, one cycle per write.
- rd_en, input, 1, read strobe, one cycle per read.
- addr, input, ADDR_W, register address.
- data_in, input, DATA_W, write data.
- data_out, output, DATA_W, registered read data.
- led_port, output, NUM_LEDS, registered LED drive; 1 = lit.

Behaviour:
- Reset: on nreset==0 at a rising edge, every register, counter, data_out and led_port clears to 0. This applies mid-operation and overrides wr_en/rd_en in the same cycle.
- Register map (unlisted bits read 0 and ignore writes):
  - 0x00 CTRL: bit0 = global enable.
  - 0x01 BLINK_DIV: DATA_W bits.
  - 0x02 STATUS: read-only, current led_port value.
  - 0x04+2i MODE_i: bits[1:0].
  - 0x05+2i DUTY_i: PWM_W bits.
- Mode encoding: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- Write: when wr_en is high at edge k, the addressed register holds data_in after edge k.
  - Writes to unmapped addresses or STATUS are ignored.
- Read: when rd_en is high at edge k, data_out holds the addressed value after edge k. Latency is 1 cycle.
  - data_out holds its last value when rd_en is low.
  - Unmapped addresses return 0.
- Simultaneous wr_en and rd_en to the same address: the read returns the pre-write value. The write still lands.
- Prescaler:
  - Counts 0..PRESC_DIV-1 and asserts tick for one cycle at PRESC_DIV-1, then wraps.
  - PRESC_DIV=1 gives tick every cycle.
- PWM counter:
  - PWM_W bits, increments on tick, wraps 2^PWM_W-1 -> 0.
  - wrap_evt = tick while the counter is at its maximum.
- Blink:
  - blink_cnt increments on wrap_evt.
  - On a wrap_evt with blink_cnt==BLINK_DIV, blink_phase toggles and blink_cnt clears.
  - Half-period = (BLINK_DIV+1) PWM periods. blink_phase starts at 0 (off).
- Channel i output, computed combinationally and registered into led_port[i]:
  - OFF -> 0.
  - ON -> 1.
  - BLINK -> blink_phase.
  - PWM -> (pwm_cnt < DUTY_i).
  - DUTY=0 is always dark; DUTY=max is lit (2^PWM_W-1)/2^PWM_W of the time.
- Latency: a register write at edge k is visible on led_port after edge k+1.
- CTRL.enable=0:
  - led_port forced to 0 at the next edge.
  - Prescaler, pwm_cnt, blink_cnt and blink_phase are held at 0, so timing restarts cleanly on re-enable.
  - Config registers are retained.
- Config changes mid-period take effect immediately; counters are not reset.
  - BLINK_DIV lowered below the current blink_cnt: blink_cnt wraps naturally through its full range before the next match. This is acceptable and documented.

Decomposition:
- Shared package led_pwm_pkg holds:
  - mode encodings (MODE_OFF/ON/BLINK/PWM);
  - register addresses (ADDR_CTRL, ADDR_BLINK_DIV, ADDR_STATUS, ADDR_CH_BASE) and the channel stride of 2.
- One sub-module, led_pwm_timebase: prescaler, pwm_cnt, blink_cnt, blink_phase.
  - Inputs: clk, nreset, enable, blink_div.
  - Outputs: pwm_cnt, blink_phase.
- The top level holds the register file, read mux and per-channel output logic, using a generate loop over NUM_LEDS.

Test Plan:
- Reset: hold nreset=0 for 2 cycles with wr_en=1, addr=0, data_in=0xFF -> led_port=0x00, data_out=0x00, CTRL reads back 0x00.
- Basic on: write CTRL=0x01, then MODE_0=0x01 -> led_port[0]=1 after the second edge following the write. Read MODE_0 -> data_out=0x01 one cycle after rd_en. Read STATUS -> 0x01.
- PWM: PRESC_DIV=1, MODE_3=0x03.
  - DUTY_3=0x40 -> led_port[3] high exactly 64 of every 256 cycles.
  - DUTY_3=0x00 -> never high.
  - DUTY_3=0xFF -> high 255 of every 256 cycles.
- Blink: PRESC_DIV=1, BLINK_DIV=0x01, MODE_5=0x02 -> led_port[5] off for 512 cycles, then on for 512, repeating.
- Bus corners:
  - Same-cycle rd_en+wr_en to DUTY_1 (old 0x10, new 0x20) -> data_out=0x10, and a later read returns 0x20.
  - Write 0x1F (unmapped) -> no register changes and a read returns 0x00.
- Disable/reset mid-run: with PWM and blink active, write CTRL=0 -> led_port=0 next edge. Re-enable -> pwm_cnt restarts at 0. Pulse nreset mid-period -> all state is 0 the following cycle.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared definitions for the LED PWM controller: channel modes and register map.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } led_mode_e;

  localparam int unsigned ADDR_CTRL      = 0;
  localparam int unsigned ADDR_BLINK_DIV = 1;
  localparam int unsigned ADDR_STATUS    = 2;
  localparam int unsigned ADDR_CH_BASE   = 4;
  localparam int unsigned CH_STRIDE      = 2;

  function automatic int unsigned mode_addr(input int unsigned ch);
    return ADDR_CH_BASE + CH_STRIDE * ch;
  endfunction

  function automatic int unsigned duty_addr(input int unsigned ch);
    return ADDR_CH_BASE + CH_STRIDE * ch + 1;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Simple wr_en/rd_en register bus shared by the fabric peripherals.
interface led_pwm_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output wr_en, rd_en, addr, data_in, input data_out);
  modport slave  (input wr_en, rd_en, addr, data_in, output data_out);
endinterface

// File: rtl/led_pwm_timebase.sv
// Shared timebase: prescaler tick, free-running PWM counter and blink phase.
module led_pwm_timebase #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              enable,
  input  logic [DATA_W-1:0] blink_div,
  output logic [PWM_W-1:0]  pwm_cnt,
  output logic              blink_phase
);

  localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [DATA_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               tick;
  logic               wrap_evt;

  always_comb begin
    tick          = (presc_q == PRESC_MAX);
    wrap_evt      = tick && (pwm_q == '1);
    presc_d       = tick ? '0 : presc_q + 1'b1;
    pwm_d         = tick ? pwm_q + 1'b1 : pwm_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    // Exact-match compare: lowering blink_div below the count lets it run the full range first.
    if (wrap_evt) begin
      if (blink_cnt_q == blink_div) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    if (!enable) begin
      presc_d       = '0;
      pwm_d         = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      presc_q       <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign pwm_cnt     = pwm_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Bus-addressed LED controller: per-channel off/on/blink/PWM modes over a shared timebase.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned PRESC_DIV = 4
) (
  input  logic                clk,
  input  logic                nreset,
  led_pwm_ctrl_if.slave       bus,
  output logic [NUM_LEDS-1:0] led_port
);

  logic                enable_q, enable_d;
  logic [DATA_W-1:0]   blink_div_q, blink_div_d;
  led_mode_e           mode_q [NUM_LEDS];
  led_mode_e           mode_d [NUM_LEDS];
  logic [PWM_W-1:0]    duty_q [NUM_LEDS];
  logic [PWM_W-1:0]    duty_d [NUM_LEDS];
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [DATA_W-1:0]   rd_data;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [PWM_W-1:0]    pwm_cnt;
  logic                blink_phase;

  led_pwm_timebase #(
    .DATA_W    (DATA_W),
    .PWM_W     (PWM_W),
    .PRESC_DIV (PRESC_DIV)
  ) u_timebase (
    .clk         (clk),
    .nreset      (nreset),
    .enable      (enable_q),
    .blink_div   (blink_div_q),
    .pwm_cnt     (pwm_cnt),
    .blink_phase (blink_phase)
  );

  always_comb begin
    enable_d    = enable_q;
    blink_div_d = blink_div_q;
    mode_d      = mode_q;
    duty_d      = duty_q;
    if (bus.wr_en) begin
      if (bus.addr == ADDR_W'(ADDR_CTRL))      enable_d    = bus.data_in[0];
      if (bus.addr == ADDR_W'(ADDR_BLINK_DIV)) blink_div_d = bus.data_in;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        if (bus.addr == ADDR_W'(mode_addr(i))) mode_d[i] = led_mode_e'(bus.data_in[1:0]);
        if (bus.addr == ADDR_W'(duty_addr(i))) duty_d[i] = bus.data_in[PWM_W-1:0];
      end
    end
  end

  // Read mux sees only _q state, so a same-cycle write returns the pre-write value.
  always_comb begin
    rd_data = '0;
    if (bus.addr == ADDR_W'(ADDR_CTRL))      rd_data = DATA_W'(enable_q);
    if (bus.addr == ADDR_W'(ADDR_BLINK_DIV)) rd_data = blink_div_q;
    if (bus.addr == ADDR_W'(ADDR_STATUS))    rd_data = DATA_W'(led_q);
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (bus.addr == ADDR_W'(mode_addr(i))) rd_data = DATA_W'(mode_q[i]);
      if (bus.addr == ADDR_W'(duty_addr(i))) rd_data = DATA_W'(duty_q[i]);
    end
    data_out_d = bus.rd_en ? rd_data : data_out_q;
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    logic lit;
    always_comb begin
      lit = 1'b0;
      unique case (mode_q[g])
        MODE_OFF:   lit = 1'b0;
        MODE_ON:    lit = 1'b1;
        MODE_BLINK: lit = blink_phase;
        MODE_PWM:   lit = (pwm_cnt < duty_q[g]);
        default:    lit = 1'b0;
      endcase
    end
    assign led_d[g] = enable_q & lit;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      enable_q    <= 1'b0;
      blink_div_q <= '0;
      data_out_q  <= '0;
      led_q       <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= MODE_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      enable_q    <= enable_d;
      blink_div_q <= blink_div_d;
      data_out_q  <= data_out_d;
      led_q       <= led_d;
      mode_q      <= mode_d;
      duty_q      <= duty_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign led_port     = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: stimulus queues expectations, a monitor checks them.
module tb_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] led_port;

  always #5 clk = ~clk;

  led_pwm_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  led_pwm_ctrl #(
    .NUM_LEDS  (8),
    .DATA_W    (8),
    .ADDR_W    (5),
    .PWM_W     (8),
    .PRESC_DIV (1)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .bus      (bus),
    .led_port (led_port)
  );

  typedef struct {
    string       name;
    bit          is_dout;
    logic [7:0]  mask;
    int unsigned len;
    int unsigned exp;
  } obs_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_t;

  obs_t obs_q[$];
  rd_t  rd_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stalls   = 0;
  bit          end_req  = 1'b0;
  bit          done     = 1'b0;

  obs_t        cur;
  rd_t         rcur;
  bit          active = 1'b0;
  bit          rd_fire;
  int unsigned left, acc;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    rd_fire = bus.rd_en;
    #1;
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        rcur = rd_q.pop_front();
        check(rcur.name, bus.data_out, rcur.exp);
      end
    end
    if (!active && obs_q.size() > 0) begin
      cur    = obs_q.pop_front();
      active = 1'b1;
      left   = cur.len;
      acc    = 0;
    end
    if (active) begin
      if (cur.is_dout) begin
        check(cur.name, bus.data_out, cur.exp);
        active = 1'b0;
      end else begin
        if ((led_port & cur.mask) != 8'h00) acc++;
        left--;
        if (left == 0) begin
          check(cur.name, acc, cur.exp);
          active = 1'b0;
        end
      end
    end
    if (end_req && !done) begin
      check("sb_drain", obs_q.size() + rd_q.size() + int'(active) + stalls, 0);
      done = 1'b1;
    end
  end

  function automatic void obs(input string n, input bit d, input logic [7:0] m,
                              input int unsigned l, input int unsigned e);
    obs_t o;
    o.name = n; o.is_dout = d; o.mask = m; o.len = l; o.exp = e;
    obs_q.push_back(o);
  endfunction

  task automatic wr_start(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_start(a, d);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] e, input string n);
    rd_t r;
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    r.name = n; r.exp = e;
    rd_q.push_back(r);
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4000; i++) begin
      if (obs_q.size() == 0 && rd_q.size() == 0 && !active) break;
      @(negedge clk);
    end
    if (obs_q.size() != 0 || rd_q.size() != 0 || active) stalls++;
  endtask

  initial begin
    rd_t r;
    nreset      = 1'b0;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b0;
    bus.addr    = 5'h00;
    bus.data_in = 8'hFF;
    obs("rst_led", 1'b0, 8'hFF, 2, 0);
    obs("rst_dout", 1'b1, 8'h00, 1, 8'h00);
    repeat (2) @(negedge clk);
    nreset    = 1'b1;
    bus.wr_en = 1'b0;
    rd(5'h00, 8'h00, "rst_ctrl");
    drain();

    // Basic on
    wr(5'h00, 8'h01);
    @(negedge clk);
    wr_start(5'h04, 8'h01);
    obs("on_pre", 1'b0, 8'h01, 1, 0);
    obs("on_led0", 1'b0, 8'h01, 1, 1);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rd(5'h04, 8'h01, "rd_mode0");
    rd(5'h02, 8'h01, "rd_status");
    rd(5'h00, 8'h01, "rd_ctrl");
    drain();

    // PWM duty sweep on channel 3
    wr(5'h0A, 8'h03);
    wr(5'h0B, 8'h40);
    obs("pwm_duty40", 1'b0, 8'h08, 256, 64);
    drain();
    wr(5'h0B, 8'h00);
    obs("pwm_duty00", 1'b0, 8'h08, 256, 0);
    drain();
    wr(5'h0B, 8'hFF);
    obs("pwm_dutyff", 1'b0, 8'h08, 256, 255);
    drain();
    wr(5'h0B, 8'h80);
    obs("pwm_duty80", 1'b0, 8'h08, 512, 256);
    drain();
    rd(5'h0B, 8'h80, "rd_duty3");

    // Bus corners
    wr(5'h07, 8'h10);
    @(negedge clk);
    wr_start(5'h07, 8'h20);
    bus.rd_en = 1'b1;
    r.name = "rdwr_old"; r.exp = 8'h10;
    rd_q.push_back(r);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rd(5'h07, 8'h20, "rdwr_new");
    wr(5'h1F, 8'hAB);
    rd(5'h1F, 8'h00, "rd_unmapped");
    rd(5'h0F, 8'h00, "unmapped_alias");
    rd(5'h03, 8'h00, "rd_hole");
    rd(5'h00, 8'h01, "ctrl_kept");
    rd(5'h01, 8'h00, "blinkdiv_kept");
    drain();

    // Blink from a clean timebase start
    wr(5'h00, 8'h00);
    obs("dis_led", 1'b0, 8'hFF, 1, 0);
    wr(5'h01, 8'h01);
    wr(5'h0E, 8'h02);
    wr(5'h0B, 8'h40);
    wr(5'h00, 8'h01);
    obs("blink_off1", 1'b0, 8'h20, 512, 0);
    obs("blink_on1", 1'b0, 8'h20, 512, 512);
    obs("blink_off2", 1'b0, 8'h20, 512, 0);
    drain();
    rd(5'h01, 8'h01, "rd_blinkdiv");
    obs("dout_hold", 1'b1, 8'h00, 1, 8'h01);
    drain();

    // Disable mid-run, then re-enable
    @(negedge clk);
    wr_start(5'h00, 8'h00);
    obs("dis_pre", 1'b0, 8'h01, 1, 1);
    obs("dis_next", 1'b0, 8'hFF, 1, 0);
    obs("dis_hold", 1'b0, 8'hFF, 20, 0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    drain();
    wr(5'h00, 8'h01);
    obs("reen_pwm_hi", 1'b0, 8'h08, 64, 64);
    obs("reen_pwm_lo", 1'b0, 8'h08, 192, 0);
    obs("reen_blink_off", 1'b0, 8'h20, 256, 0);
    obs("reen_blink_on", 1'b0, 8'h20, 1, 1);
    drain();
    rd(5'h0E, 8'h02, "rd_mode5");

    // Reset pulse mid-period
    @(negedge clk);
    nreset = 1'b0;
    obs("rstm_led", 1'b0, 8'hFF, 1, 0);
    obs("rstm_dout", 1'b1, 8'h00, 1, 8'h00);
    @(negedge clk);
    nreset = 1'b1;
    obs("rstm_dark", 1'b0, 8'hFF, 8, 0);
    rd(5'h00, 8'h00, "rstm_ctrl");
    rd(5'h04, 8'h00, "rstm_mode0");
    rd(5'h0B, 8'h00, "rstm_duty3");
    rd(5'h01, 8'h00, "rstm_blinkdiv");
    rd(5'h07, 8'h00, "rstm_duty1");
    drain();

    @(negedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
